// File: rtl/register_file_2r1w.sv
// General-purpose register file: two combinational read ports, one synchronous write port.
// Optional write-through forwarding on both read ports when REGFILE_BYPASS_EN is defined.
module register_file_2r1w #(
  parameter int unsigned REG_ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      write_en,
  input  logic [REG_ADDR_WIDTH-1:0] reg1,
  input  logic [REG_ADDR_WIDTH-1:0] reg2,
  input  logic [REG_ADDR_WIDTH-1:0] regw,
  input  logic [DATA_WIDTH-1:0]     dataw,
  output logic [DATA_WIDTH-1:0]     data1,
  output logic [DATA_WIDTH-1:0]     data2
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  // Storage: async clear has priority over any write in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        mem[i] <= '0;
      end
    end else if (write_en) begin
      mem[regw] <= dataw;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic hit1;
  logic hit2;

  // Forward the write data in the write cycle; suppressed while reset is held.
  always_comb begin
    hit1  = rst_n && write_en && (reg1 == regw);
    hit2  = rst_n && write_en && (reg2 == regw);
    data1 = hit1 ? dataw : mem[reg1];
    data2 = hit2 ? dataw : mem[reg2];
  end
`else
  always_comb begin
    data1 = mem[reg1];
    data2 = mem[reg2];
  end
`endif

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed self-checking bench for register_file_2r1w (either build of REGFILE_BYPASS_EN).
module tb_register_file_2r1w;

  logic       clk;
  logic       rst_n;
  logic       write_en;
  logic [3:0] reg1;
  logic [3:0] reg2;
  logic [3:0] regw;
  logic [7:0] dataw;
  logic [7:0] data1;
  logic [7:0] data2;

  int passed;
  int total;

  register_file_2r1w #(.REG_ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .write_en(write_en),
    .reg1(reg1), .reg2(reg2), .regw(regw), .dataw(dataw),
    .data1(data1), .data2(data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [3:0] addr, input logic [7:0] val);
    @(negedge clk);
    write_en = 1'b1;
    regw     = addr;
    dataw    = val;
    @(posedge clk);
    #1;
    write_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; write_en = 1'b0; reg1 = 4'd0; reg2 = 4'd9; regw = 4'd0; dataw = 8'h00;
    #1;
    total++;
    if (data1 !== 8'h00) $display("FAIL reset_data1 got %h want 00", data1); else passed++;
    total++;
    if (data2 !== 8'h00) $display("FAIL reset_data2 got %h want 00", data2); else passed++;
    // Write attempted during reset must be ignored.
    @(negedge clk);
    write_en = 1'b1; regw = 4'd9; dataw = 8'hEE;
    @(posedge clk); #1;
    write_en = 1'b0;
    total++;
    if (data2 !== 8'h00) $display("FAIL reset_priority got %h want 00", data2); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (data2 !== 8'h00) $display("FAIL reset_release got %h want 00", data2); else passed++;
  endtask

  task automatic test_write_read;
    do_write(4'd1, 8'hFF);
    reg2 = 4'd1; reg1 = 4'd0;
    #1;
    total++;
    if (data2 !== 8'hFF) $display("FAIL wr_r1 got %h want ff", data2); else passed++;
    total++;
    if (data1 !== 8'h00) $display("FAIL wr_r0 got %h want 00", data1); else passed++;
  endtask

  task automatic test_write_disabled;
    @(negedge clk);
    write_en = 1'b0; regw = 4'd2; dataw = 8'h33; reg1 = 4'd2;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (data1 !== 8'h00) $display("FAIL wr_disabled got %h want 00", data1); else passed++;
    total++;
    if (data2 !== 8'hFF) $display("FAIL wr_disabled_r1 got %h want ff", data2); else passed++;
  endtask

  task automatic test_dual_port;
    do_write(4'd15, 8'hA5);
    reg1 = 4'd15; reg2 = 4'd15;
    #1;
    total++;
    if (data1 !== 8'hA5) $display("FAIL dual_data1 got %h want a5", data1); else passed++;
    total++;
    if (data2 !== 8'hA5) $display("FAIL dual_data2 got %h want a5", data2); else passed++;
    do_write(4'd0, 8'h11);
    reg1 = 4'd0;
    #1;
    total++;
    if (data1 !== 8'h11) $display("FAIL r0_write got %h want 11", data1); else passed++;
  endtask

  task automatic test_collision;
    logic [7:0] exp_before;
`ifdef REGFILE_BYPASS_EN
    exp_before = 8'h20;
`else
    exp_before = 8'h10;
`endif
    do_write(4'd4, 8'h10);
    @(negedge clk);
    write_en = 1'b1; regw = 4'd4; dataw = 8'h20; reg1 = 4'd4; reg2 = 4'd5;
    #1;
    total++;
    if (data1 !== exp_before) $display("FAIL collide_before got %h want %h", data1, exp_before); else passed++;
    total++;
    if (data2 !== 8'h00) $display("FAIL collide_other_port got %h want 00", data2); else passed++;
    @(posedge clk); #1;
    write_en = 1'b0;
    total++;
    if (data1 !== 8'h20) $display("FAIL collide_after got %h want 20", data1); else passed++;
  endtask

  task automatic test_sweep;
    logic [7:0] e1;
    logic [7:0] e2;
    for (int i = 0; i < 16; i++) do_write(4'(i), 8'(i) ^ 8'h5A);
    for (int i = 0; i < 16; i++) begin
      reg1 = 4'(i);
      reg2 = 4'(15 - i);
      e1 = 8'(i) ^ 8'h5A;
      e2 = 8'(15 - i) ^ 8'h5A;
      #1;
      total++;
      if (data1 !== e1) $display("FAIL sweep_p1[%0d] got %h want %h", i, data1, e1); else passed++;
      total++;
      if (data2 !== e2) $display("FAIL sweep_p2[%0d] got %h want %h", 15 - i, data2, e2); else passed++;
    end
  endtask

  task automatic test_async_reset_mid;
    do_write(4'd3, 8'h5A);
    reg1 = 4'd3;
    #1;
    total++;
    if (data1 !== 8'h5A) $display("FAIL r3_before_reset got %h want 5a", data1); else passed++;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    // Still between edges here: clear must not need a clock.
    total++;
    if (data1 !== 8'h00) $display("FAIL async_clear got %h want 00", data1); else passed++;
    for (int i = 0; i < 16; i++) begin
      reg1 = 4'(i);
      reg2 = 4'(i);
      #1;
      total++;
      if (data1 !== 8'h00 || data2 !== 8'h00)
        $display("FAIL reset_all[%0d] got %h/%h want 00/00", i, data1, data2);
      else passed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset;
    test_write_read;
    test_write_disabled;
    test_dual_port;
    test_collision;
    test_sweep;
    test_async_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
